// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control logic: controller states,
// the NOP encoding loaded by the flushes, and default stall parameters.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        VECWAIT = 2'd2
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          LD_STALL_DEF   = 1;
    localparam int          VEC_CYCLES_DEF = 4;

    // True when a DECO source field is in use and names the EXE destination.
    function automatic logic src_match(input logic use_src,
                                       input logic [3:0] src,
                                       input logic [3:0] dst);
        return use_src & (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Count enabled cycles, holding at all-ones once reached.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the FETCH/DECO/EXE/MEM pipeline: load-use stalls,
// multi-cycle vector occupancy of EXE and taken-branch flushes.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LD_STALL   = LD_STALL_DEF,
    parameter int VEC_CYCLES = VEC_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       RP_deco,
    input  logic [3:0]       RS_deco,
    input  logic             use_rp_deco,
    input  logic             use_rs_deco,
    input  logic [3:0]       Rg_exe,
    input  logic             mem_rd_exe,
    input  logic             we_v_exe,
    input  logic             salto_exe,
    output logic             pc_hold,
    output logic             en_fd,
    output logic             en_de,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             pc_sel_branch,
    output logic [CNT_W-1:0] stall_cnt
);

    // The entry cycle and the final cnt==0 cycle both count, hence the -2.
    localparam logic [3:0] LD_RELOAD  = 4'(LD_STALL - 2);
    localparam logic [3:0] VEC_RELOAD = 4'(VEC_CYCLES - 2);
    localparam logic       LD_MULTI   = (LD_STALL > 1) ? 1'b1 : 1'b0;

    hz_state_t  r_state;
    hz_state_t  w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       w_hz;

    assign w_hz = mem_rd_exe & (src_match(use_rp_deco, RP_deco, Rg_exe) |
                                src_match(use_rs_deco, RS_deco, Rg_exe));

    // Mealy outputs and next-state selection from current state and inputs.
    always_comb begin
        pc_hold       = 1'b0;
        en_fd         = 1'b1;
        en_de         = 1'b1;
        flush_fd      = 1'b0;
        flush_de      = 1'b0;
        flush_em      = 1'b0;
        pc_sel_branch = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        if (rst) begin
            flush_fd     = 1'b1;
            flush_de     = 1'b1;
            flush_em     = 1'b1;
            w_next_state = RUN;
            w_next_cnt   = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (salto_exe) begin
                        flush_fd      = 1'b1;
                        flush_de      = 1'b1;
                        pc_sel_branch = 1'b1;
                    end else if (we_v_exe) begin
                        pc_hold      = 1'b1;
                        en_fd        = 1'b0;
                        en_de        = 1'b0;
                        flush_em     = 1'b1;
                        w_next_cnt   = VEC_RELOAD;
                        w_next_state = VECWAIT;
                    end else if (w_hz) begin
                        pc_hold  = 1'b1;
                        en_fd    = 1'b0;
                        flush_de = 1'b1;
                        if (LD_MULTI) begin
                            w_next_cnt   = LD_RELOAD;
                            w_next_state = LDSTALL;
                        end else begin
                            w_next_state = RUN;
                        end
                    end else begin
                        w_next_state = RUN;
                    end
                end
                LDSTALL: begin
                    pc_hold  = 1'b1;
                    en_fd    = 1'b0;
                    flush_de = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end
                VECWAIT: begin
                    pc_hold = 1'b1;
                    en_fd   = 1'b0;
                    en_de   = 1'b0;
                    // Last cycle lets the vector result advance into MEM.
                    if (r_cnt != 4'd0) begin
                        flush_em   = 1'b1;
                        w_next_cnt = r_cnt - 4'd1;
                    end else begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (pc_hold),
        .o_q   (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: four parameterisations share one stimulus stream and
// are checked every cycle against a countdown-based model of the pipeline rules.
module tb_hazard_ctrl;

    localparam int N = 4;
    localparam int LDP [N] = '{1, 3, 7, 2};
    localparam int VCP [N] = '{4, 4, 2, 15};
    localparam int WP  [N] = '{16, 16, 4, 5};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] RP_deco, RS_deco, Rg_exe;
    logic       use_rp_deco, use_rs_deco, mem_rd_exe, we_v_exe, salto_exe;

    logic        o_ph [N];
    logic        o_efd [N];
    logic        o_ede [N];
    logic        o_ffd [N];
    logic        o_fde [N];
    logic        o_fem [N];
    logic        o_psb [N];
    logic [15:0] o_sc [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic w_ph, w_efd, w_ede, w_ffd, w_fde, w_fem, w_psb;
        logic [WP[g]-1:0] w_sc;
        hazard_ctrl #(.LD_STALL(LDP[g]), .VEC_CYCLES(VCP[g]), .CNT_W(WP[g])) u_dut (
            .clk(clk), .rst(rst),
            .RP_deco(RP_deco), .RS_deco(RS_deco),
            .use_rp_deco(use_rp_deco), .use_rs_deco(use_rs_deco),
            .Rg_exe(Rg_exe), .mem_rd_exe(mem_rd_exe),
            .we_v_exe(we_v_exe), .salto_exe(salto_exe),
            .pc_hold(w_ph), .en_fd(w_efd), .en_de(w_ede),
            .flush_fd(w_ffd), .flush_de(w_fde), .flush_em(w_fem),
            .pc_sel_branch(w_psb), .stall_cnt(w_sc)
        );
        assign o_ph[g]  = w_ph;
        assign o_efd[g] = w_efd;
        assign o_ede[g] = w_ede;
        assign o_ffd[g] = w_ffd;
        assign o_fde[g] = w_fde;
        assign o_fem[g] = w_fem;
        assign o_psb[g] = w_psb;
        assign o_sc[g]  = 16'(w_sc);
    end

    int total = 0;
    int bad   = 0;
    int stepno = 0;

    // Model: remaining hold cycles of an ongoing load-use stall / vector op.
    int m_ld [N];
    int m_vec [N];
    int m_sc [N];

    // Per-window observation of the DUTs for the literal expectations.
    int   n_hold [N];
    int   n_ede0 [N];
    int   n_fem [N];
    logic s_ph [N];
    logic s_efd [N];
    logic s_ede [N];
    logic s_ffd [N];
    logic s_fde [N];
    logic s_fem [N];
    logic s_psb [N];
    int   s_sc [N];

    task automatic check_bit(input string name, input int i, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] step=%0d got=%0b want=%0b", name, i, stepno, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[u%0d] step=%0d got=%0d want=%0d", name, i, stepno, act, exp);
        end
    endtask

    task automatic clear_window();
        for (int i = 0; i < N; i++) begin
            n_hold[i] = 0;
            n_ede0[i] = 0;
            n_fem[i]  = 0;
        end
    endtask

    task automatic set_idle();
        rst = 1'b0; RP_deco = 4'd0; RS_deco = 4'd0; Rg_exe = 4'd0;
        use_rp_deco = 1'b0; use_rs_deco = 1'b0;
        mem_rd_exe = 1'b0; we_v_exe = 1'b0; salto_exe = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] rp);
        set_idle();
        mem_rd_exe = 1'b1; Rg_exe = 4'd5; RP_deco = rp; use_rp_deco = 1'b1;
    endtask

    // One clock: compare all DUTs to the model mid-cycle, then advance the model.
    task automatic step();
        logic ph, efd, ede, ffd, fde, fem, psb, hz;
        int nld [N];
        int nvec [N];
        int nsc [N];
        @(negedge clk);
        hz = mem_rd_exe & ((use_rp_deco & (RP_deco == Rg_exe)) |
                           (use_rs_deco & (RS_deco == Rg_exe)));
        for (int i = 0; i < N; i++) begin
            ph = 1'b0; efd = 1'b1; ede = 1'b1; ffd = 1'b0; fde = 1'b0; fem = 1'b0; psb = 1'b0;
            nld[i] = m_ld[i]; nvec[i] = m_vec[i];
            if (rst) begin
                ffd = 1'b1; fde = 1'b1; fem = 1'b1;
                nld[i] = 0; nvec[i] = 0;
            end else if (m_vec[i] > 0) begin
                ph = 1'b1; efd = 1'b0; ede = 1'b0; fem = (m_vec[i] > 1);
                nvec[i] = m_vec[i] - 1;
            end else if (m_ld[i] > 0) begin
                ph = 1'b1; efd = 1'b0; fde = 1'b1;
                nld[i] = m_ld[i] - 1;
            end else if (salto_exe) begin
                ffd = 1'b1; fde = 1'b1; psb = 1'b1;
            end else if (we_v_exe) begin
                ph = 1'b1; efd = 1'b0; ede = 1'b0; fem = 1'b1;
                nvec[i] = VCP[i] - 1;
            end else if (hz) begin
                ph = 1'b1; efd = 1'b0; fde = 1'b1;
                nld[i] = LDP[i] - 1;
            end
            if (rst) nsc[i] = 0;
            else if (ph && m_sc[i] < (1 << WP[i]) - 1) nsc[i] = m_sc[i] + 1;
            else nsc[i] = m_sc[i];

            check_bit("pc_hold", i, o_ph[i], ph);
            check_bit("en_fd", i, o_efd[i], efd);
            check_bit("en_de", i, o_ede[i], ede);
            check_bit("flush_fd", i, o_ffd[i], ffd);
            check_bit("flush_de", i, o_fde[i], fde);
            check_bit("flush_em", i, o_fem[i], fem);
            check_bit("pc_sel_branch", i, o_psb[i], psb);
            if (stepno > 0) check_int("stall_cnt", i, int'(o_sc[i]), m_sc[i]);

            s_ph[i] = o_ph[i]; s_efd[i] = o_efd[i]; s_ede[i] = o_ede[i];
            s_ffd[i] = o_ffd[i]; s_fde[i] = o_fde[i]; s_fem[i] = o_fem[i];
            s_psb[i] = o_psb[i]; s_sc[i] = int'(o_sc[i]);
            n_hold[i] += int'(o_ph[i]);
            n_ede0[i] += int'(!o_ede[i]);
            n_fem[i]  += int'(o_fem[i]);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_ld[i] = nld[i]; m_vec[i] = nvec[i]; m_sc[i] = nsc[i];
        end
        stepno++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_ld[i] = 0; m_vec[i] = 0; m_sc[i] = 0;
        end
        clear_window();

        // Reset with random inputs for two cycles.
        for (int k = 0; k < 2; k++) begin
            rst = 1'b1;
            RP_deco = 4'($urandom); RS_deco = 4'($urandom); Rg_exe = 4'($urandom);
            use_rp_deco = 1'($urandom); use_rs_deco = 1'($urandom);
            mem_rd_exe = 1'($urandom); we_v_exe = 1'($urandom); salto_exe = 1'($urandom);
            step();
        end
        check_bit("rst_flush_fd", 0, s_ffd[0], 1'b1);
        check_bit("rst_flush_em", 0, s_fem[0], 1'b1);
        check_bit("rst_pc_hold", 0, s_ph[0], 1'b0);
        check_bit("rst_en_de", 0, s_ede[0], 1'b1);
        check_bit("rst_pc_sel", 0, s_psb[0], 1'b0);
        check_int("rst_stall_cnt", 0, s_sc[0], 0);

        set_idle();
        step();

        // Load-use hazard on r5 for one cycle.
        clear_window();
        set_load_use(4'd5);
        step();
        set_idle();
        repeat (10) step();
        check_int("ld_holds", 0, n_hold[0], 1);
        check_int("ld_holds", 1, n_hold[1], 3);
        check_int("ld_holds", 2, n_hold[2], 7);
        check_int("ld_holds", 3, n_hold[3], 2);
        check_int("ld_stall_cnt", 0, s_sc[0], 1);
        check_int("ld_stall_cnt", 1, s_sc[1], 3);

        // Non-matching source register: no hazard.
        clear_window();
        set_load_use(4'd6);
        step();
        set_idle();
        repeat (4) step();
        check_int("nomatch_holds", 1, n_hold[1], 0);

        // Vector op pulse.
        clear_window();
        set_idle();
        we_v_exe = 1'b1;
        step();
        set_idle();
        repeat (20) step();
        check_int("vec_ende0", 0, n_ede0[0], 4);
        check_int("vec_flush_em", 0, n_fem[0], 3);
        check_int("vec_holds", 2, n_hold[2], 2);
        check_int("vec_flush_em", 2, n_fem[2], 1);
        check_int("vec_holds", 3, n_hold[3], 15);

        // Branch together with a load-use hazard.
        clear_window();
        set_load_use(4'd5);
        salto_exe = 1'b1;
        step();
        check_bit("br_flush_fd", 1, s_ffd[1], 1'b1);
        check_bit("br_flush_de", 1, s_fde[1], 1'b1);
        check_bit("br_pc_sel", 1, s_psb[1], 1'b1);
        check_bit("br_pc_hold", 1, s_ph[1], 1'b0);
        set_idle();
        step();
        check_int("br_stall_cnt", 1, s_sc[1], 7);
        check_int("br_stall_cnt", 0, s_sc[0], 5);
        check_int("br_holds", 1, n_hold[1], 0);

        // Reset during the second cycle of a vector wait.
        set_idle();
        we_v_exe = 1'b1;
        step();
        set_idle();
        rst = 1'b1;
        step();
        set_idle();
        step();
        check_bit("rstvec_en_de", 0, s_ede[0], 1'b1);
        check_bit("rstvec_pc_hold", 0, s_ph[0], 1'b0);
        check_int("rstvec_stall_cnt", 0, s_sc[0], 0);

        // Continuous load-use hazards hold the PC long enough to saturate narrow counters.
        set_load_use(4'd5);
        repeat (40) step();
        set_idle();
        step();
        check_int("sat_stall_cnt", 2, s_sc[2], 15);
        check_int("sat_stall_cnt", 3, s_sc[3], 31);
        check_int("sat_stall_cnt", 0, s_sc[0], 40);

        // Randomised traffic with small register numbers to provoke matches.
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 99) == 0);
            salto_exe   = ($urandom_range(0, 7) == 0);
            we_v_exe    = ($urandom_range(0, 11) == 0);
            mem_rd_exe  = 1'($urandom_range(0, 1));
            use_rp_deco = 1'($urandom_range(0, 1));
            use_rs_deco = 1'($urandom_range(0, 1));
            RP_deco     = 4'($urandom_range(0, 3));
            RS_deco     = 4'($urandom_range(0, 3));
            Rg_exe      = 4'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
